layer_compositor: RTL and testbench

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/compositor_pkg.sv | 17 +
 rtl/blend_unit.sv | 42 ++++
 rtl/layer_compositor.sv | 200 ++++++++++++++++++++
 tb/tb_layer_compositor.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
// Shared definitions for the layer compositor: per-layer blend mode
// encodings and the damage-flash state enum.
package compositor_pkg;

    typedef enum logic [1:0] {
        MODE_TRANSP = 2'b00,
        MODE_HALF   = 2'b01,
        MODE_OPAQUE = 2'b10,
        MODE_ADD    = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

endpackage

// File: rtl/blend_unit.sv
// One compositing step: blends a single layer pixel over the running
// accumulator according to that layer's 2-bit mode, per colour channel.
module blend_unit
    import compositor_pkg::*;
#(
    parameter int COLOR_W = 4
) (
    input  logic [3*COLOR_W-1:0] layer_i,
    input  logic [1:0]           mode_i,
    input  logic [3*COLOR_W-1:0] acc_i,
    output logic [3*COLOR_W-1:0] acc_o
);

    // Per-channel blend; the sum carries one extra bit so the half-blend
    // and the saturation test both see the true sum.
    function automatic logic [COLOR_W-1:0] blend_ch(
        input logic [COLOR_W-1:0] lyr,
        input logic [COLOR_W-1:0] acc,
        input logic [1:0]         mode
    );
        logic [COLOR_W:0] sum;
        sum = {1'b0, lyr} + {1'b0, acc};
        case (mode_e'(mode))
            MODE_TRANSP: blend_ch = acc;
            MODE_HALF:   blend_ch = sum[COLOR_W:1];
            MODE_OPAQUE: blend_ch = lyr;
            MODE_ADD:    blend_ch = sum[COLOR_W] ? {COLOR_W{1'b1}} : sum[COLOR_W-1:0];
            default:     blend_ch = acc;
        endcase
    endfunction

    // Apply the blend independently to r, g and b.
    always_comb begin
        acc_o = acc_i;
        for (int c = 0; c < 3; c++) begin
            acc_o[c*COLOR_W +: COLOR_W] = blend_ch(layer_i[c*COLOR_W +: COLOR_W],
                                                   acc_i[c*COLOR_W +: COLOR_W],
                                                   mode_i);
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage layer compositor: S1 registers the inputs, S2 composites the
// layers from background to front, S3 applies damage-flash tint, crosshair
// overlay and blanking. A small FSM counts frames of the damage flash.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 6,
    parameter int COLOR_W      = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int CROSS_EN     = 1,
    parameter int CROSS_X      = 320,
    parameter int CROSS_Y      = 240,
    parameter int CROSS_LEN    = 5
) (
    input  logic                            vga_clk,
    input  logic                            Reset,
    input  logic                            vga_blank,
    input  logic [9:0]                      vga_x,
    input  logic [9:0]                      vga_y,
    input  logic                            frame_start,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
    input  logic [2*NUM_LAYERS-1:0]         layer_a,
    input  logic                            hit,
    output logic [COLOR_W-1:0]              r,
    output logic [COLOR_W-1:0]              g,
    output logic [COLOR_W-1:0]              b,
    output logic                            flash_active
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int CNT_W = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

    // ---------------- S1: input register ----------------
    logic                            s1_blank_q;
    logic [9:0]                      s1_x_q, s1_y_q;
    logic [NUM_LAYERS*PIX_W-1:0]     s1_rgb_q;
    logic [2*NUM_LAYERS-1:0]         s1_a_q;

    // Capture all pixel inputs every cycle.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            s1_blank_q <= 1'b0;
            s1_x_q     <= 10'd0;
            s1_y_q     <= 10'd0;
            s1_rgb_q   <= '0;
            s1_a_q     <= '0;
        end else begin
            s1_blank_q <= vga_blank;
            s1_x_q     <= vga_x;
            s1_y_q     <= vga_y;
            s1_rgb_q   <= layer_rgb;
            s1_a_q     <= layer_a;
        end
    end

    // ---------------- S2: composite chain ----------------
    // acc_s[i] is the accumulator after layer i has been applied; the
    // background seeds the top of the chain and its mode is never looked at.
    logic [PIX_W-1:0] acc_s [NUM_LAYERS];

    assign acc_s[NUM_LAYERS-1] = s1_rgb_q[(NUM_LAYERS-1)*PIX_W +: PIX_W];

    for (genvar gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_blend
        blend_unit #(.COLOR_W(COLOR_W)) u_blend (
            .layer_i (s1_rgb_q[gi*PIX_W +: PIX_W]),
            .mode_i  (s1_a_q[2*gi +: 2]),
            .acc_i   (acc_s[gi+1]),
            .acc_o   (acc_s[gi])
        );
    end

    logic             s2_blank_q;
    logic [9:0]       s2_x_q, s2_y_q;
    logic [PIX_W-1:0] s2_rgb_q;

    // Register the composite together with its delayed timing signals.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            s2_blank_q <= 1'b0;
            s2_x_q     <= 10'd0;
            s2_y_q     <= 10'd0;
            s2_rgb_q   <= '0;
        end else begin
            s2_blank_q <= s1_blank_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
            s2_rgb_q   <= acc_s[0];
        end
    end

    // ---------------- Flash FSM ----------------
    flash_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Flash state and frame counter register.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A hit always (re)loads the full duration; otherwise each frame start
    // burns one frame and the flash ends when the count runs out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hit) begin
            state_d = FLASH;
            cnt_d   = CNT_W'(FLASH_FRAMES);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
                FLASH: begin
                    if (frame_start) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = FLASH;
                            cnt_d   = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        state_d = FLASH;
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign flash_active = (state_q == FLASH);

    // ---------------- S3: tint / crosshair / blank ----------------
    logic signed [11:0] dx_s, dy_s;
    logic [11:0]        adx_s, ady_s;
    logic               cross_s;

    assign dx_s  = $signed({2'b00, s2_x_q}) - $signed(12'(CROSS_X));
    assign dy_s  = $signed({2'b00, s2_y_q}) - $signed(12'(CROSS_Y));
    assign adx_s = dx_s[11] ? 12'(-dx_s) : 12'(dx_s);
    assign ady_s = dy_s[11] ? 12'(-dy_s) : 12'(dy_s);

    // Horizontal arm on the centre row, vertical arm two pixels wide.
    always_comb begin
        cross_s = 1'b0;
        if (CROSS_EN != 0) begin
            cross_s = ((adx_s < 12'(CROSS_LEN)) && (dy_s == 12'sd0)) ||
                      (((dx_s == -12'sd1) || (dx_s == 12'sd0)) &&
                       (ady_s <= 12'(CROSS_LEN + 1)));
        end else begin
            cross_s = 1'b0;
        end
    end

    logic [PIX_W-1:0]   out_d, out_q;
    logic [COLOR_W:0]   tint_r_s;

    assign tint_r_s = {1'b0, s2_rgb_q[2*COLOR_W +: COLOR_W]} + {1'b0, {COLOR_W{1'b1}}};

    // Blanking beats the crosshair, which beats the red damage tint.
    always_comb begin
        out_d = s2_rgb_q;
        if (!s2_blank_q) begin
            out_d = '0;
        end else if (cross_s) begin
            out_d = {PIX_W{1'b1}};
        end else if (state_q == FLASH) begin
            out_d = {tint_r_s[COLOR_W:1],
                     1'b0, s2_rgb_q[COLOR_W+1 +: COLOR_W-1],
                     1'b0, s2_rgb_q[1 +: COLOR_W-1]};
        end else begin
            out_d = s2_rgb_q;
        end
    end

    // Output colour register.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign r = out_q[2*COLOR_W +: COLOR_W];
    assign g = out_q[COLOR_W +: COLOR_W];
    assign b = out_q[0 +: COLOR_W];

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios on a
// 6-layer / 2-frame-flash instance plus a random-mode scoreboard run on
// 2-, 6- and 8-layer instances against a behavioural reference model.
module tb_layer_compositor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       blank = 1'b0;
    logic [9:0] px = 10'd0;
    logic [9:0] py = 10'd0;
    logic       fs = 1'b0;
    logic       hit = 1'b0;

    logic [71:0] lrgb6 = '0;
    logic [11:0] la6 = '0;
    logic [23:0] lrgb2 = '0;
    logic [3:0]  la2 = '0;
    logic [95:0] lrgb8 = '0;
    logic [15:0] la8 = '0;

    logic [3:0] r6, g6, b6, r2, g2, b2, r8, g8, b8;
    logic       fa6, fa2, fa8;

    int n_cmp = 0;
    int n_err = 0;

    int c6[8], m6[8], c2[8], m2[8], c8[8], m8[8];

    always #5 clk = ~clk;

    layer_compositor #(.NUM_LAYERS(6), .COLOR_W(4), .FLASH_FRAMES(2)) dut6 (
        .vga_clk(clk), .Reset(rst), .vga_blank(blank), .vga_x(px), .vga_y(py),
        .frame_start(fs), .layer_rgb(lrgb6), .layer_a(la6), .hit(hit),
        .r(r6), .g(g6), .b(b6), .flash_active(fa6));

    layer_compositor #(.NUM_LAYERS(2), .COLOR_W(4)) dut2 (
        .vga_clk(clk), .Reset(rst), .vga_blank(blank), .vga_x(px), .vga_y(py),
        .frame_start(fs), .layer_rgb(lrgb2), .layer_a(la2), .hit(hit),
        .r(r2), .g(g2), .b(b2), .flash_active(fa2));

    layer_compositor #(.NUM_LAYERS(8), .COLOR_W(4)) dut8 (
        .vga_clk(clk), .Reset(rst), .vga_blank(blank), .vga_x(px), .vga_y(py),
        .frame_start(fs), .layer_rgb(lrgb8), .layer_a(la8), .hit(hit),
        .r(r8), .g(g8), .b(b8), .flash_active(fa8));

    // ---------------- reference model ----------------
    function automatic int ref_comp(input int nl, input int cols[8], input int modes[8]);
        int acc[3];
        int l;
        for (int c = 0; c < 3; c++) acc[c] = (cols[nl-1] >> (8 - 4*c)) & 15;
        for (int i = nl - 2; i >= 0; i--) begin
            for (int c = 0; c < 3; c++) begin
                l = (cols[i] >> (8 - 4*c)) & 15;
                case (modes[i])
                    1: acc[c] = (l + acc[c]) / 2;
                    2: acc[c] = l;
                    3: acc[c] = (l + acc[c] > 15) ? 15 : l + acc[c];
                    default: ;
                endcase
            end
        end
        return (acc[0] << 8) | (acc[1] << 4) | acc[2];
    endfunction

    function automatic int ref_out(input int pix, input bit bl, input int x, input int y,
                                   input bit fl);
        int dx, dy, rr, gg, bb;
        dx = x - 320;
        dy = y - 240;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (!bl) return 0;
        if ((dx < 5 && y == 240) || ((x == 319 || x == 320) && dy <= 6)) return 12'hFFF;
        if (!fl) return pix;
        rr = (((pix >> 8) & 15) + 15) / 2;
        gg = ((pix >> 4) & 15) / 2;
        bb = (pix & 15) / 2;
        return (rr << 8) | (gg << 4) | bb;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_layers();
        for (int i = 0; i < 6; i++) begin
            lrgb6[i*12 +: 12] = 12'(c6[i]);
            la6[i*2 +: 2]     = 2'(m6[i]);
        end
        for (int i = 0; i < 2; i++) begin
            lrgb2[i*12 +: 12] = 12'(c2[i]);
            la2[i*2 +: 2]     = 2'(m2[i]);
        end
        for (int i = 0; i < 8; i++) begin
            lrgb8[i*12 +: 12] = 12'(c8[i]);
            la8[i*2 +: 2]     = 2'(m8[i]);
        end
    endtask

    task automatic clear_layers();
        for (int i = 0; i < 8; i++) begin
            c6[i] = 0; m6[i] = 0; c2[i] = 0; m2[i] = 0; c8[i] = 0; m8[i] = 0;
        end
        drive_layers();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_layers();
        blank = 1'b1; px = 10'd10; py = 10'd10;
        c6[5] = 12'h5A5; drive_layers();
        rst = 1'b1; hit = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'h000) begin
            n_err++; $display("FAIL reset_rgb: got %h want 000", {r6, g6, b6});
        end
        n_cmp++;
        if ({fa6, fa2, fa8} !== 3'b000) begin
            n_err++; $display("FAIL reset_flash: got %b want 000", {fa6, fa2, fa8});
        end
        rst = 1'b0; hit = 1'b0;
        tick();
        n_cmp++;
        if (fa6 !== 1'b0) begin
            n_err++; $display("FAIL hit_in_reset_ignored: got %b want 0", fa6);
        end
        tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'h000) begin
            n_err++; $display("FAIL post_release_zero: got %h want 000", {r6, g6, b6});
        end
        tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'h5A5) begin
            n_err++; $display("FAIL first_valid_pixel: got %h want 5a5", {r6, g6, b6});
        end
    endtask

    task automatic test_opaque();
        int e;
        clear_layers();
        repeat (4) tick();
        c6[5] = 12'h123;
        c6[2] = 12'hF00; m6[2] = 2;
        c6[0] = 12'h0F0; m6[0] = 2;
        drive_layers();
        e = ref_out(ref_comp(6, c6, m6), 1'b1, 10, 10, 1'b0);
        tick(); tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'h000) begin
            n_err++; $display("FAIL opaque_early: got %h want 000", {r6, g6, b6});
        end
        tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'(e)) begin
            n_err++; $display("FAIL opaque_latency3: got %h want %h", {r6, g6, b6}, 12'(e));
        end
    endtask

    task automatic test_half_add();
        int col0[3];
        int e;
        col0[0] = -1; col0[1] = 12'h999; col0[2] = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            clear_layers();
            c6[5] = 12'h888;
            c6[1] = 12'h000; m6[1] = 1;
            if (col0[k] >= 0) begin
                c6[0] = col0[k]; m6[0] = 3;
            end
            drive_layers();
            e = ref_out(ref_comp(6, c6, m6), 1'b1, 10, 10, 1'b0);
            repeat (3) tick();
            n_cmp++;
            if ({r6, g6, b6} !== 12'(e)) begin
                n_err++; $display("FAIL half_add_%0d: got %h want %h", k, {r6, g6, b6}, 12'(e));
            end
        end
    endtask

    task automatic pulse_fs(input bit with_hit);
        fs = 1'b1; hit = with_hit;
        tick();
        fs = 1'b0; hit = 1'b0;
    endtask

    task automatic test_flash();
        int base;
        clear_layers();
        c6[5] = 12'h0F8; drive_layers();
        base = ref_comp(6, c6, m6);
        repeat (3) tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'(base) || fa6 !== 1'b0) begin
            n_err++; $display("FAIL flash_pre: got %h/%b want %h/0", {r6, g6, b6}, fa6, 12'(base));
        end
        hit = 1'b1; tick(); hit = 1'b0;
        n_cmp++;
        if (fa6 !== 1'b1) begin
            n_err++; $display("FAIL flash_start: got %b want 1", fa6);
        end
        tick(); tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'(ref_out(base, 1'b1, 10, 10, 1'b1))) begin
            n_err++; $display("FAIL flash_tint: got %h want %h", {r6, g6, b6},
                              12'(ref_out(base, 1'b1, 10, 10, 1'b1)));
        end
        pulse_fs(1'b0);
        n_cmp++;
        if (fa6 !== 1'b1) begin
            n_err++; $display("FAIL flash_frame1: got %b want 1", fa6);
        end
        pulse_fs(1'b0);
        n_cmp++;
        if (fa6 !== 1'b0) begin
            n_err++; $display("FAIL flash_end: got %b want 0", fa6);
        end
        repeat (3) tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'(base)) begin
            n_err++; $display("FAIL flash_untinted: got %h want %h", {r6, g6, b6}, 12'(base));
        end
        // hit coinciding with the second frame start reloads the duration
        hit = 1'b1; tick(); hit = 1'b0;
        pulse_fs(1'b0);
        pulse_fs(1'b1);
        pulse_fs(1'b0);
        n_cmp++;
        if (fa6 !== 1'b1) begin
            n_err++; $display("FAIL hit_wins_frame1: got %b want 1", fa6);
        end
        pulse_fs(1'b0);
        n_cmp++;
        if (fa6 !== 1'b0) begin
            n_err++; $display("FAIL hit_wins_end: got %b want 0", fa6);
        end
    endtask

    task automatic test_cross();
        int xs[6], ys[6], e, base;
        xs[0] = 320; ys[0] = 240;
        xs[1] = 324; ys[1] = 240;
        xs[2] = 325; ys[2] = 240;
        xs[3] = 319; ys[3] = 246;
        xs[4] = 319; ys[4] = 247;
        xs[5] = 316; ys[5] = 240;
        base = ref_comp(6, c6, m6);
        hit = 1'b1; tick(); hit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            px = 10'(xs[k]); py = 10'(ys[k]);
            e = ref_out(base, 1'b1, xs[k], ys[k], 1'b1);
            repeat (3) tick();
            n_cmp++;
            if ({r6, g6, b6} !== 12'(e)) begin
                n_err++; $display("FAIL cross_%0d_%0d: got %h want %h", xs[k], ys[k],
                                  {r6, g6, b6}, 12'(e));
            end
        end
        px = 10'd320; py = 10'd240; blank = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'h000) begin
            n_err++; $display("FAIL blank_over_cross: got %h want 000", {r6, g6, b6});
        end
        blank = 1'b1; px = 10'd10; py = 10'd10;
    endtask

    task automatic test_reset_mid_flash();
        int base;
        base = ref_comp(6, c6, m6);
        hit = 1'b1; tick(); hit = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if (fa6 !== 1'b0 || {r6, g6, b6} !== 12'h000) begin
            n_err++; $display("FAIL reset_abort: got %b/%h want 0/000", fa6, {r6, g6, b6});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if ({r6, g6, b6} !== 12'h000) begin
                n_err++; $display("FAIL release_zero_%0d: got %h want 000", k, {r6, g6, b6});
            end
        end
        tick();
        n_cmp++;
        if ({r6, g6, b6} !== 12'(base)) begin
            n_err++; $display("FAIL release_valid: got %h want %h", {r6, g6, b6}, 12'(base));
        end
    endtask

    task automatic test_random_sweep();
        int e6[200], e2[200], e8[200];
        int bl[200];
        int xx, yy;
        rst = 1'b1; hit = 1'b0; fs = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int n = 0; n < 203; n++) begin
            tick();
            if (n >= 3) begin
                n_cmp++;
                if ({r6, g6, b6} !== 12'(e6[n-3])) begin
                    n_err++; $display("FAIL sweep6_%0d: got %h want %h", n-3, {r6, g6, b6}, 12'(e6[n-3]));
                end
                n_cmp++;
                if ({r2, g2, b2} !== 12'(e2[n-3])) begin
                    n_err++; $display("FAIL sweep2_%0d: got %h want %h", n-3, {r2, g2, b2}, 12'(e2[n-3]));
                end
                n_cmp++;
                if ({r8, g8, b8} !== 12'(e8[n-3])) begin
                    n_err++; $display("FAIL sweep8_%0d: got %h want %h", n-3, {r8, g8, b8}, 12'(e8[n-3]));
                end
            end
            if (n < 200) begin
                for (int i = 0; i < 8; i++) begin
                    c6[i] = $urandom_range(4095, 0); m6[i] = $urandom_range(3, 0);
                    c2[i] = $urandom_range(4095, 0); m2[i] = $urandom_range(3, 0);
                    c8[i] = $urandom_range(4095, 0); m8[i] = $urandom_range(3, 0);
                end
                drive_layers();
                bl[n] = ($urandom_range(7, 0) != 0) ? 1 : 0;
                if ($urandom_range(3, 0) == 0) begin
                    xx = $urandom_range(330, 310); yy = $urandom_range(250, 230);
                end else begin
                    xx = $urandom_range(1023, 0); yy = $urandom_range(1023, 0);
                end
                blank = bl[n][0]; px = 10'(xx); py = 10'(yy);
                e6[n] = ref_out(ref_comp(6, c6, m6), bl[n][0], xx, yy, 1'b0);
                e2[n] = ref_out(ref_comp(2, c2, m2), bl[n][0], xx, yy, 1'b0);
                e8[n] = ref_out(ref_comp(8, c8, m8), bl[n][0], xx, yy, 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_half_add();
        test_flash();
        test_cross();
        test_reset_mid_flash();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
